// File: rtl/alu_32.sv
// 32-bit ALU with a start/done handshake: seven single-cycle operations plus an
// unsigned modulo computed by a 32-iteration restoring divider.
module alu_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;

  // Single-cycle operation results, taken straight from the live inputs at acceptance
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (sel)
      3'b000:  alu_s = in1 & in2;
      3'b001:  alu_s = in1 | in2;
      3'b010:  alu_s = in1 ^ in2;
      3'b011:  alu_s = ~(in1 | in2);
      3'b100:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      3'b101:  alu_s = in1 + in2;
      3'b110:  alu_s = in1 - in2;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // One restoring step: 33 bits wide so the shifted remainder cannot overflow
  assign trial_s = {rem_q, dvd_q[cnt_q]};
  assign diff_s  = trial_s - {1'b0, dvs_q};

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          dvd_d = in1;
          dvs_d = in2;
          rem_d = {WIDTH{1'b0}};
          quo_d = {WIDTH{1'b0}};
          cnt_d = CW'(WIDTH - 1);
          if (sel == OP_MOD) begin
            state_d = S_BUSY;
          end else begin
            result_d = alu_s;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (dvs_q == {WIDTH{1'b0}}) begin
          // x mod 0 is defined here as x; no iterations are run
          result_d = dvd_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          if (trial_s >= {1'b0, dvs_q}) begin
            rem_d = diff_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = trial_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == {CW{1'b0}}) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FIN: begin
        result_d = rem_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dvd_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_32.sv
// Scoreboard bench for alu_32: driver pushes expected result and done cycle,
// a monitor pops and compares on every rising edge of done.
module tb_alu_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in1, in2;
  logic [2:0]  sel;
  logic [31:0] result;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] last_res = 32'd0;
  logic        prev_done = 1'b0;

  alu_32 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .sel    (sel),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] s);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    return a + b;
      3'd6:    return a - b;
      default: return (b == 32'd0) ? a : (a % b);
    endcase
  endfunction

  // Edges between the accepting edge and the edge at which done rises
  function automatic int latency(input logic [31:0] b, input logic [2:0] s);
    if (s != 3'd7) return 0;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  // Monitor: compare on rising done, check hold while done stays high
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: result=%h with no operation pending", result);
        end else begin
          mon_e = exp_q.pop_front();
          if (result !== mon_e.res) begin
            failures++;
            $display("FAIL result: got %h expected %h", result, mon_e.res);
          end
          checks++;
          if (cyc != mon_e.due) begin
            failures++;
            $display("FAIL done_latency: done rose at cycle %0d expected %0d", cyc, mon_e.due);
          end
          last_res = mon_e.res;
        end
      end else if (done && prev_done) begin
        checks++;
        if (result !== last_res) begin
          failures++;
          $display("FAIL result_hold: got %h expected %h", result, last_res);
        end
      end
      prev_done = done;
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                       input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    in1   = a;
    in2   = b;
    sel   = s;
    start = 1'b1;
    e.res = model(a, b, s);
    e.due = cyc + 1 + latency(b, s);
    exp_q.push_back(e);
    n = 0;
    // Scramble inputs while the operation is in flight
    do begin
      @(negedge clk);
      in1 = $urandom;
      in2 = $urandom;
      sel = 3'($urandom_range(0, 7));
      n++;
    end while (!done && n < 60);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: done=%b after %0d cycles, expected 1", done, n);
      exp_q.delete();
    end
    if (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (result !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s: result=%h done=%b expected result=0 done=0", name, result, done);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    in1   = 32'd0;
    in2   = 32'd0;
    sel   = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_state");
    @(negedge clk);
    check_idle("idle_after_reset");

    do_op(32'd20, 32'd3, 3'd7, 1'b1);
    do_op(32'hFFFF_FFFF, 32'd7, 3'd7, 1'b0);
    do_op(32'd5, 32'd9, 3'd7, 1'b0);
    do_op(32'd123, 32'd0, 3'd7, 1'b1);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 1'b0);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd1, 1'b0);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 1'b1);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd3, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
    do_op(32'd0, 32'd1, 3'd6, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0);
    do_op(32'd1, 32'hFFFF_FFFF, 3'd4, 1'b0);

    // Abort a modulo in progress with reset
    @(negedge clk);
    in1   = 32'd1000;
    in2   = 32'd7;
    sel   = 3'd7;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_abort");
    do_op(32'd20, 32'd3, 3'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      do_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit ALU with a start/done handshake.
- Seven single-cycle operations: bitwise, add, subtract, set-less-than.
- One multi-cycle unsigned modulo (sel=3'b111), built as a 32-iteration restoring divider.
- Used as the arithmetic block of the project datapath; the controller issues start, then waits for done before sampling result.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is required to work.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- in1  input  32  operand A (dividend for modulo)
- in2  input  32  operand B (divisor for modulo)
- sel  input  3  operation select
- result  output  32  registered result
- done  output  1  high while result is valid

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset: on a rising clk edge with reset=1, the block enters IDLE with result=0, done=0, and internal remainder, quotient and counter cleared.
- Reset takes priority over everything, including an operation in progress, which is aborted.
- Operation codes:
  - 000: in1 & in2
  - 001: in1 | in2
  - 010: in1 ^ in2
  - 011: ~(in1 | in2)
  - 100: signed less-than; result = {31'b0, $signed(in1) < $signed(in2)}
  - 101: in1 + in2, wraps mod 2^32, no carry out
  - 110: in1 - in2, wraps mod 2^32
  - 111: in1 mod in2, unsigned
- States:
  - IDLE: done=0. On start=1, latch in1, in2 and sel into internal registers. For sel != 111 go to DONE; for sel = 111 go to BUSY. Later changes on in1/in2/sel do not affect the operation in flight.
  - Single-cycle ops: at the edge where start is accepted, result is written, and done=1 from that edge. Latency is 1 cycle.
  - BUSY (modulo): restoring algorithm, one quotient bit per cycle, MSB first, counter 31 down to 0. Each cycle: rem = {rem[30:0], dividend bit}; if rem >= divisor then rem = rem - divisor. Use a 33-bit compare/subtract so there is no overflow. After the 32nd iteration, result = rem, go to DONE, done=1. done therefore rises 33 clock edges after the accepting edge.
  - Divisor = 0: skip iteration; result = latched in1, go to DONE at the next edge.
  - DONE: done=1, result held stable. While start=1, stay in DONE with no re-trigger. When start=0, go to IDLE; done drops, result keeps its last value.
  - A new operation requires start to be low for at least one cycle, then high again.
- Quotient is computed internally but not exported.

Test Plan:
- reset=1 for 2 cycles, then reset=0 with start=0 -> result=0, done=0, state IDLE.
- sel=111, in1=20, in2=3, start held high -> done rises 33 edges after acceptance; result=2; result and done still 2/1 one cycle later.
- sel=111 corner cases:
  - in1=0xFFFFFFFF, in2=7 -> result=3
  - in1=5, in2=9 -> result=5
  - in1=123, in2=0 -> result=123 with done after 1 cycle
- Single-cycle ops with in1=0xF0F0F0F0, in2=0x0FF00FF0, one start pulse each, done next cycle:
  - 000 -> 0x00F000F0
  - 001 -> 0xFFF0FFF0
  - 010 -> 0xFF00FF00
  - 011 -> 0x000F000F
- Arithmetic and compare:
  - 101: 0xFFFFFFFF + 1 -> 0
  - 110: 0 - 1 -> 0xFFFFFFFF
  - 100: in1=0xFFFFFFFF, in2=1 -> 1; swapped operands -> 0
- Mid-operation events:
  - Change in1/in2 during BUSY -> original result unaffected.
  - Assert reset during BUSY -> next cycle done=0, result=0.
  - A following start with 20 mod 3 -> 2.
